inverter_sweep_checker: RTL and testbench

- Sequential stimulus/response stage wrapped around the 3-input inverter network.
- Upstream role: drives every input pattern into the inverter, one after another.
- Downstream role: samples the inverter's output for each pattern and checks it against the bitwise complement of the input.
- Replaces the unclocked delay-based tester with a synthesizable, clocked self-check that can run on hardware. It reports pass/fail, an error count and the first failing pattern.

---
 rtl/inverter_check_pkg.sv | 19 +
 rtl/sweep_pattern_counter.sv | 28 ++
 rtl/inverter_sweep_checker.sv | 133 +++++++++++++
 tb/tb_inverter_sweep_checker.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/inverter_check_pkg.sv
// Shared types and helpers for the inverter sweep checker.
// Holds the sweep FSM state encoding and the reference model.
package inverter_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Wide all-ones value; users truncate to their bus width.
  localparam logic [31:0] TERMINAL_PATTERN = '1;

  function automatic logic [31:0] expected_out(input logic [31:0] in);
    return ~in;
  endfunction

endpackage

// File: rtl/sweep_pattern_counter.sv
// Pattern register for the sweep: load-zero, increment, last flag.
// Never wraps; the terminal pattern is flagged instead.
module sweep_pattern_counter
  import inverter_check_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_zero,
  input  logic             inc,
  output logic [WIDTH-1:0] pattern,
  output logic             is_last
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern <= '0;
    end else if (load_zero) begin
      pattern <= '0;
    end else if (inc && !is_last) begin
      pattern <= pattern + WIDTH'(1);
    end
  end

  assign is_last = (pattern == WIDTH'(TERMINAL_PATTERN));

endmodule

// File: rtl/inverter_sweep_checker.sv
// Clocked stimulus/response checker for a WIDTH-bit inverter.
// Sweeps every pattern, counts mismatches, records the first one.
module inverter_sweep_checker
  import inverter_check_pkg::*;
#(
  parameter int WIDTH         = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic             fail_strobe,
  output logic             first_fail_valid,
  output logic [WIDTH-1:0] first_fail_pattern,
  output logic [WIDTH-1:0] first_fail_got
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   settle_cnt;
  logic            settle_last;
  logic            load_zero;
  logic            inc;
  logic            is_last;
  logic            mismatch;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] expect_out;

  sweep_pattern_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load_zero(load_zero),
    .inc      (inc),
    .pattern  (pattern),
    .is_last  (is_last)
  );

  assign dut_in      = pattern;
  assign expect_out  = WIDTH'(expected_out(32'(pattern)));
  assign mismatch    = (dut_out != expect_out);
  assign settle_last = (settle_cnt == CW'(SETTLE_CYCLES - 1));

  always_comb begin
    state_next  = state;
    load_zero   = 1'b0;
    inc         = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    fail_strobe = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load_zero  = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_last) state_next = CHECK;
      end
      CHECK: begin
        busy        = 1'b1;
        fail_strobe = mismatch;
        if (is_last) begin
          state_next = DONE;
        end else begin
          inc        = 1'b1;
          state_next = SETTLE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load_zero  = 1'b1;
          state_next = SETTLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pass = done && (err_count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      settle_cnt         <= '0;
      err_count          <= '0;
      first_fail_valid   <= 1'b0;
      first_fail_pattern <= '0;
      first_fail_got     <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            settle_cnt         <= '0;
            err_count          <= '0;
            first_fail_valid   <= 1'b0;
            first_fail_pattern <= '0;
            first_fail_got     <= '0;
          end
        end
        SETTLE: begin
          if (!settle_last) settle_cnt <= settle_cnt + CW'(1);
        end
        CHECK: begin
          settle_cnt <= '0;
          if (mismatch) begin
            err_count <= err_count + (WIDTH + 1)'(1);
            if (!first_fail_valid) begin
              first_fail_valid   <= 1'b1;
              first_fail_pattern <= pattern;
              first_fail_got     <= dut_out;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inverter_sweep_checker.sv
// Directed bench for inverter_sweep_checker with a behavioural DUT.
// Modes: 0 good inverter, 1 bit0 stuck at 0, 2 identity.
module tb_inverter_sweep_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic [1:0] mode = 2'd0;

  logic [2:0] dut_in, dut_out, ffp, ffg;
  logic       busy, done, pass, fstr, ffv;
  logic [3:0] errc;

  logic [2:0] dut_in2, dut_out2, ffp2, ffg2;
  logic       busy2, done2, pass2, fstr2, ffv2;
  logic [3:0] errc2;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign dut_out = (mode == 2'd0) ? ~dut_in :
                   (mode == 2'd1) ? (~dut_in & 3'b110) : dut_in;
  assign dut_out2 = ~dut_in2;

  inverter_sweep_checker #(.WIDTH(3), .SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass),
    .err_count(errc), .fail_strobe(fstr),
    .first_fail_valid(ffv), .first_fail_pattern(ffp),
    .first_fail_got(ffg)
  );

  inverter_sweep_checker #(.WIDTH(3), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start2),
    .dut_in(dut_in2), .dut_out(dut_out2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(errc2), .fail_strobe(fstr2),
    .first_fail_valid(ffv2), .first_fail_pattern(ffp2),
    .first_fail_got(ffg2)
  );

  typedef struct {
    logic [1:0] mode;
    int         cycles;
    int         err;
    logic       pass;
    logic       ffv;
    logic [2:0] ffp;
    logic [2:0] ffg;
    int         strobes;
  } vec_t;

  vec_t vecs[3];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_outs"},
        int'({dut_in, busy, done, pass, errc, fstr, ffv, ffp, ffg}), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_to_done(output int cycles, output int strobes);
    cycles  = 0;
    strobes = 0;
    while (!done && cycles < 200) begin
      if (fstr) strobes++;
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  int cyc, stb;

  initial begin
    vecs[0] = '{2'd0, 16, 0, 1'b1, 1'b0, 3'b000, 3'b000, 0};
    vecs[1] = '{2'd1, 16, 4, 1'b0, 1'b1, 3'b000, 3'b110, 4};
    vecs[2] = '{2'd2, 16, 8, 1'b0, 1'b1, 3'b000, 3'b000, 8};

    do_reset();
    check_idle("reset");

    for (int i = 0; i < 3; i++) begin
      do_reset();
      mode = vecs[i].mode;
      pulse_start();
      chk($sformatf("v%0d_busy", i), int'(busy), 1);
      run_to_done(cyc, stb);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cycles);
      chk($sformatf("v%0d_err", i), int'(errc), vecs[i].err);
      chk($sformatf("v%0d_pass", i), int'(pass), int'(vecs[i].pass));
      chk($sformatf("v%0d_ffv", i), int'(ffv), int'(vecs[i].ffv));
      chk($sformatf("v%0d_ffp", i), int'(ffp), int'(vecs[i].ffp));
      chk($sformatf("v%0d_ffg", i), int'(ffg), int'(vecs[i].ffg));
      chk($sformatf("v%0d_strobes", i), stb, vecs[i].strobes);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d_hold", i),
          int'({done, busy, dut_in, errc}),
          int'({1'b1, 1'b0, 3'b111, 4'(vecs[i].err)}));
    end

    // Start while busy, then reset mid-sweep.
    do_reset();
    mode = 2'd2;
    pulse_start();
    cyc = 0;
    while (dut_in != 3'd3 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("reach_p3", int'(dut_in), 3);
    chk("p3_err", int'(errc), 3);
    pulse_start();
    chk("busy_start_p", int'({dut_in, errc}), int'({3'd3, 4'd3}));
    @(posedge clk);
    #1;
    chk("busy_start_n", int'({dut_in, errc, busy}),
        int'({3'd4, 4'd4, 1'b1}));
    cyc = 0;
    while (dut_in != 3'd5 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("reach_p5", int'(dut_in), 5);
    do_reset();
    check_idle("midreset");
    mode = 2'd0;
    pulse_start();
    chk("restart_p0", int'({dut_in, busy}), int'({3'd0, 1'b1}));
    run_to_done(cyc, stb);
    chk("restart_res", int'({pass, errc, cyc[7:0]}),
        int'({1'b1, 4'd0, 8'd16}));

    // Stuck-at run, then restart from DONE with a good DUT.
    do_reset();
    mode = 2'd1;
    pulse_start();
    run_to_done(cyc, stb);
    chk("stuck_err", int'(errc), 4);
    mode = 2'd0;
    pulse_start();
    chk("clear_on_start",
        int'({done, errc, ffv, ffp, ffg, dut_in}), 0);
    run_to_done(cyc, stb);
    chk("rerun_res", int'({pass, errc, ffv, stb[3:0]}),
        int'({1'b1, 4'd0, 1'b0, 4'd0}));

    // SETTLE_CYCLES=3 instance.
    do_reset();
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    stb = 0;
    for (int c = 0; c < 32; c++) begin
      if (dut_in2 != 3'(c / 4) || done2 || fstr2) stb++;
      @(posedge clk);
      #1;
    end
    chk("s3_hold_errs", stb, 0);
    chk("s3_done", int'({done2, pass2, errc2}),
        int'({1'b1, 1'b1, 4'd0}));

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
